// File: rtl/hazard_id_ex_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hazard_id_ex_if : ID-stage inputs, ID/EX register outputs, hazard enables.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface hazard_id_ex_if #(
  parameter int DW = 32,
  parameter int CW = 32
);
  logic [DW-1:0] inst_ID, rd1_ID, rd2_ID, imm_ID;
  logic          reg_write_ID, mem_read_ID, mem_write_ID, mem_to_reg_ID;
  logic          alu_src_ID, reg_dst_ID;
  logic [1:0]    alu_op_ID;
  logic          ex_flush;
  logic          mem_read_MEM;
  logic [4:0]    write_dst_MEM;

  logic          pc_write, if_id_write;
  logic [4:0]    rs_EX, rt_EX, rd_EX, write_dst_EX;
  logic [DW-1:0] rd1_EX, rd2_EX, imm_EX;
  logic          reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX;
  logic          alu_src_EX, reg_dst_EX;
  logic [1:0]    alu_op_EX;
  logic [CW-1:0] stall_count;

  modport master (
    output inst_ID, rd1_ID, rd2_ID, imm_ID,
    output reg_write_ID, mem_read_ID, mem_write_ID, mem_to_reg_ID,
    output alu_src_ID, reg_dst_ID, alu_op_ID,
    output ex_flush, mem_read_MEM, write_dst_MEM,
    input  pc_write, if_id_write,
    input  rs_EX, rt_EX, rd_EX, write_dst_EX, rd1_EX, rd2_EX, imm_EX,
    input  reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX,
    input  alu_src_EX, reg_dst_EX, alu_op_EX, stall_count
  );

  modport slave (
    input  inst_ID, rd1_ID, rd2_ID, imm_ID,
    input  reg_write_ID, mem_read_ID, mem_write_ID, mem_to_reg_ID,
    input  alu_src_ID, reg_dst_ID, alu_op_ID,
    input  ex_flush, mem_read_MEM, write_dst_MEM,
    output pc_write, if_id_write,
    output rs_EX, rt_EX, rd_EX, write_dst_EX, rd1_EX, rd2_EX, imm_EX,
    output reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX,
    output alu_src_EX, reg_dst_EX, alu_op_EX, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_id_ex.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hazard_id_ex : ID/EX pipeline register with load-use / ID-branch hazards.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module hazard_id_ex #(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_id_ex_if.slave bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_BNE   = 6'd5;

  typedef struct packed {
    logic [4:0]    rs, rt, rd, wdst;
    logic [DW-1:0] rd1, rd2, imm;
    logic          reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [1:0]    alu_op;
  } ex_t;

  ex_t           ex_d, ex_q;
  logic [CW-1:0] stall_count_q;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd;
  logic       w_uses_rs, w_uses_rt, w_is_branch;
  logic       w_h1, w_h2, w_h3, w_hazard;
  logic [10:0] w_unused_inst;

  assign w_op  = bus.inst_ID[31:26];
  assign w_rs  = bus.inst_ID[25:21];
  assign w_rt  = bus.inst_ID[20:16];
  assign w_rd  = bus.inst_ID[15:11];
  assign w_unused_inst = bus.inst_ID[10:0];

  // sw is deliberately absent from uses_rt: its store data is forwarded in MEM.
  always_comb begin
    w_uses_rs = 1'b0;
    w_uses_rt = 1'b0;
    case (w_op)
      6'd0, 6'd4, 6'd5: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
      end
      6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43: w_uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign w_is_branch = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);

  assign w_h1 = ex_q.mem_read && (ex_q.wdst != 5'd0) &&
                ((w_uses_rs && (ex_q.wdst == w_rs)) ||
                 (w_uses_rt && (ex_q.wdst == w_rt)));
  assign w_h2 = w_is_branch && ex_q.reg_write && (ex_q.wdst != 5'd0) &&
                ((ex_q.wdst == w_rs) || (ex_q.wdst == w_rt));
  assign w_h3 = w_is_branch && bus.mem_read_MEM && (bus.write_dst_MEM != 5'd0) &&
                ((bus.write_dst_MEM == w_rs) || (bus.write_dst_MEM == w_rt));
  assign w_hazard = w_h1 || w_h2 || w_h3;

  assign bus.pc_write    = !w_hazard;
  assign bus.if_id_write = !w_hazard;

  always_comb begin
    ex_d = '0;
    if (!(w_hazard || bus.ex_flush)) begin
      ex_d.rs         = w_rs;
      ex_d.rt         = w_rt;
      ex_d.rd         = w_rd;
      ex_d.wdst       = bus.reg_dst_ID ? w_rd : w_rt;
      ex_d.rd1        = bus.rd1_ID;
      ex_d.rd2        = bus.rd2_ID;
      ex_d.imm        = bus.imm_ID;
      ex_d.reg_write  = bus.reg_write_ID;
      ex_d.mem_read   = bus.mem_read_ID;
      ex_d.mem_write  = bus.mem_write_ID;
      ex_d.mem_to_reg = bus.mem_to_reg_ID;
      ex_d.alu_src    = bus.alu_src_ID;
      ex_d.reg_dst    = bus.reg_dst_ID;
      ex_d.alu_op     = bus.alu_op_ID;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (w_hazard)
        stall_count_q <= stall_count_q + CW'(1);
    end
  end

  assign bus.rs_EX         = ex_q.rs;
  assign bus.rt_EX         = ex_q.rt;
  assign bus.rd_EX         = ex_q.rd;
  assign bus.write_dst_EX  = ex_q.wdst;
  assign bus.rd1_EX        = ex_q.rd1;
  assign bus.rd2_EX        = ex_q.rd2;
  assign bus.imm_EX        = ex_q.imm;
  assign bus.reg_write_EX  = ex_q.reg_write;
  assign bus.mem_read_EX   = ex_q.mem_read;
  assign bus.mem_write_EX  = ex_q.mem_write;
  assign bus.mem_to_reg_EX = ex_q.mem_to_reg;
  assign bus.alu_src_EX    = ex_q.alu_src;
  assign bus.reg_dst_EX    = ex_q.reg_dst;
  assign bus.alu_op_EX     = ex_q.alu_op;
  assign bus.stall_count   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_id_ex.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_hazard_id_ex : directed self-checking bench for hazard_id_ex.            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_hazard_id_ex;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  hazard_id_ex_if #(.DW(32), .CW(32)) bus ();

  hazard_id_ex #(.DW(32), .CW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd);
    return {6'd0, rs, rt, rd, 11'd32};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // controls: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
  task automatic drive(input logic [31:0] inst, input logic [5:0] ctl,
                       input logic [1:0] aop, input logic [31:0] d1, d2, im);
    bus.inst_ID       = inst;
    bus.reg_write_ID  = ctl[5];
    bus.mem_read_ID   = ctl[4];
    bus.mem_write_ID  = ctl[3];
    bus.mem_to_reg_ID = ctl[2];
    bus.alu_src_ID    = ctl[1];
    bus.reg_dst_ID    = ctl[0];
    bus.alu_op_ID     = aop;
    bus.rd1_ID        = d1;
    bus.rd2_ID        = d2;
    bus.imm_ID        = im;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] c_CTL_LW  = 6'b110110;
  localparam logic [5:0] c_CTL_R   = 6'b100001;
  localparam logic [5:0] c_CTL_I   = 6'b100010;
  localparam logic [5:0] c_CTL_SW  = 6'b001010;
  localparam logic [5:0] c_CTL_BR  = 6'b000000;

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    bus.ex_flush = 1'b0;
    bus.mem_read_MEM = 1'b0;
    bus.write_dst_MEM = 5'd0;
    drive(32'd0, 6'd0, 2'd0, 32'd0, 32'd0, 32'd0);

    // reset state
    #2;
    chk("rst_pc_write", 64'(bus.pc_write), 64'd1);
    chk("rst_if_id_write", 64'(bus.if_id_write), 64'd1);
    chk("rst_stall", 64'(bus.stall_count), 64'd0);
    chk("rst_wdst", 64'(bus.write_dst_EX), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // lw $2,0($1) ; add $3,$2,$4 -> one stall
    drive(i_inst(6'd35, 5'd1, 5'd2, 16'd0), c_CTL_LW, 2'd0, 32'h11, 32'h22, 32'h0);
    chk("lw_pc_write", 64'(bus.pc_write), 64'd1);
    tick();
    chk("lw_mem_read_EX", 64'(bus.mem_read_EX), 64'd1);
    chk("lw_mem_to_reg_EX", 64'(bus.mem_to_reg_EX), 64'd1);
    chk("lw_wdst", 64'(bus.write_dst_EX), 64'd2);
    drive(r_inst(5'd2, 5'd4, 5'd3), c_CTL_R, 2'd2, 32'h5, 32'h6, 32'h0);
    chk("lu_pc_write", 64'(bus.pc_write), 64'd0);
    chk("lu_if_id_write", 64'(bus.if_id_write), 64'd0);
    tick();
    chk("lu_bubble_rw", 64'(bus.reg_write_EX), 64'd0);
    chk("lu_bubble_wdst", 64'(bus.write_dst_EX), 64'd0);
    chk("lu_stall1", 64'(bus.stall_count), 64'd1);
    chk("lu_release_pc", 64'(bus.pc_write), 64'd1);
    tick();
    chk("add_rs_EX", 64'(bus.rs_EX), 64'd2);
    chk("add_rt_EX", 64'(bus.rt_EX), 64'd4);
    chk("add_wdst", 64'(bus.write_dst_EX), 64'd3);
    chk("add_reg_dst_EX", 64'(bus.reg_dst_EX), 64'd1);

    // lw $5 ; beq $5,$6 -> two stalls (H1 then H3)
    drive(i_inst(6'd35, 5'd1, 5'd5, 16'd0), c_CTL_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    chk("lw5_pc_write", 64'(bus.pc_write), 64'd1);
    tick();
    drive(i_inst(6'd4, 5'd5, 5'd6, 16'd8), c_CTL_BR, 2'd1, 32'h0, 32'h0, 32'h8);
    chk("beq_h1_pc", 64'(bus.pc_write), 64'd0);
    tick();
    bus.mem_read_MEM = 1'b1;
    bus.write_dst_MEM = 5'd5;
    #1;
    chk("beq_h3_pc", 64'(bus.pc_write), 64'd0);
    chk("beq_h3_stall", 64'(bus.stall_count), 64'd2);
    tick();
    bus.mem_read_MEM = 1'b0;
    bus.write_dst_MEM = 5'd0;
    #1;
    chk("beq_release_pc", 64'(bus.pc_write), 64'd1);
    chk("beq_stall2", 64'(bus.stall_count), 64'd3);
    tick();
    chk("beq_rs_EX", 64'(bus.rs_EX), 64'd5);
    chk("beq_rt_EX", 64'(bus.rt_EX), 64'd6);

    // addi $5,$0,1 ; beq $5,$0 -> one stall (H2)
    drive(i_inst(6'd8, 5'd0, 5'd5, 16'd1), c_CTL_I, 2'd0, 32'h0, 32'h0, 32'h1);
    chk("addi_pc", 64'(bus.pc_write), 64'd1);
    tick();
    drive(i_inst(6'd4, 5'd5, 5'd0, 16'd4), c_CTL_BR, 2'd1, 32'h0, 32'h0, 32'h4);
    chk("beq_h2_pc", 64'(bus.pc_write), 64'd0);
    tick();
    chk("beq_h2_release", 64'(bus.pc_write), 64'd1);
    chk("beq_h2_stall", 64'(bus.stall_count), 64'd4);
    tick();

    // lw $2 ; sw $2,4($7) -> no stall
    drive(i_inst(6'd35, 5'd1, 5'd2, 16'd0), c_CTL_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(i_inst(6'd43, 5'd7, 5'd2, 16'd4), c_CTL_SW, 2'd0, 32'h0, 32'h0, 32'h4);
    chk("sw_pc", 64'(bus.pc_write), 64'd1);
    tick();
    chk("sw_rt_EX", 64'(bus.rt_EX), 64'd2);
    chk("sw_mem_write_EX", 64'(bus.mem_write_EX), 64'd1);
    chk("sw_stall", 64'(bus.stall_count), 64'd4);

    // lw $0 ; add $3,$0,$0 -> no stall
    drive(i_inst(6'd35, 5'd1, 5'd0, 16'd0), c_CTL_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(r_inst(5'd0, 5'd0, 5'd3), c_CTL_R, 2'd2, 32'h0, 32'h0, 32'h0);
    chk("r0_pc", 64'(bus.pc_write), 64'd1);
    tick();
    chk("r0_wdst", 64'(bus.write_dst_EX), 64'd3);
    chk("r0_stall", 64'(bus.stall_count), 64'd4);

    // ex_flush alone
    bus.ex_flush = 1'b1;
    drive(r_inst(5'd1, 5'd2, 5'd3), c_CTL_R, 2'd2, 32'h7, 32'h8, 32'h0);
    chk("flush_pc", 64'(bus.pc_write), 64'd1);
    tick();
    chk("flush_rw", 64'(bus.reg_write_EX), 64'd0);
    chk("flush_wdst", 64'(bus.write_dst_EX), 64'd0);
    chk("flush_rd1", 64'(bus.rd1_EX), 64'd0);
    chk("flush_stall", 64'(bus.stall_count), 64'd4);
    bus.ex_flush = 1'b0;

    // ex_flush with load-use
    drive(i_inst(6'd35, 5'd1, 5'd2, 16'd0), c_CTL_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
    bus.ex_flush = 1'b1;
    drive(r_inst(5'd2, 5'd4, 5'd3), c_CTL_R, 2'd2, 32'h0, 32'h0, 32'h0);
    chk("flush_lu_pc", 64'(bus.pc_write), 64'd0);
    tick();
    chk("flush_lu_rw", 64'(bus.reg_write_EX), 64'd0);
    chk("flush_lu_stall", 64'(bus.stall_count), 64'd5);
    bus.ex_flush = 1'b0;
    tick();

    // destination select and data paths
    drive(r_inst(5'd1, 5'd2, 5'd9), c_CTL_R, 2'd2, 32'hDEADBEEF, 32'h12345678, 32'h0000FFFF);
    tick();
    chk("r_wdst", 64'(bus.write_dst_EX), 64'd9);
    chk("r_rd_EX", 64'(bus.rd_EX), 64'd9);
    chk("r_rd1_EX", 64'(bus.rd1_EX), 64'hDEADBEEF);
    chk("r_rd2_EX", 64'(bus.rd2_EX), 64'h12345678);
    chk("r_imm_EX", 64'(bus.imm_EX), 64'h0000FFFF);
    chk("r_alu_op_EX", 64'(bus.alu_op_EX), 64'd2);
    drive(i_inst(6'd8, 5'd3, 5'd4, 16'hFFF0), c_CTL_I, 2'd0, 32'hCAFEF00D, 32'h0, 32'hFFFFFFF0);
    tick();
    chk("i_wdst", 64'(bus.write_dst_EX), 64'd4);
    chk("i_imm_EX", 64'(bus.imm_EX), 64'hFFFFFFF0);
    chk("i_alu_src_EX", 64'(bus.alu_src_EX), 64'd1);
    chk("i_rd1_EX", 64'(bus.rd1_EX), 64'hCAFEF00D);

    // reset asserted mid-stall, between edges
    drive(i_inst(6'd35, 5'd1, 5'd2, 16'd0), c_CTL_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(r_inst(5'd2, 5'd4, 5'd3), c_CTL_R, 2'd2, 32'h0, 32'h0, 32'h0);
    chk("mid_pre_pc", 64'(bus.pc_write), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_mem_read_EX", 64'(bus.mem_read_EX), 64'd0);
    chk("mid_wdst", 64'(bus.write_dst_EX), 64'd0);
    chk("mid_stall", 64'(bus.stall_count), 64'd0);
    chk("mid_pc", 64'(bus.pc_write), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_wdst", 64'(bus.write_dst_EX), 64'd3);
    chk("post_rst_stall", 64'(bus.stall_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hazard_id_ex.md
Name: hazard_id_ex

Overview:
- ID/EX pipeline register combined with the hazard-detection logic of the 5-stage MIPS pipeline.
- Detects load-use hazards and the hazards of branches compared in ID.
- Drives PC / IF_ID write-enables low and inserts bubbles into ID/EX.
- Its registered outputs feed the EX stage and the forwarding unit: rs_EX, rt_EX, write_dst_EX and the control bits.

Parameters:
- DW, 32, data/instruction width
- CW, 32, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- inst_ID  in  DW  instruction in ID
- rd1_ID  in  DW  register-file read data 1
- rd2_ID  in  DW  register-file read data 2
- imm_ID  in  DW  sign-extended immediate
- reg_write_ID, mem_read_ID, mem_write_ID, mem_to_reg_ID, alu_src_ID, reg_dst_ID  in  1 each  ID control
- alu_op_ID  in  2  ALU op class
- ex_flush  in  1  force a bubble into ID/EX this edge
- mem_read_MEM  in  1  EX/MEM instruction is a load
- write_dst_MEM  in  5  EX/MEM destination register
- pc_write  out  1  PC write-enable; 0 = hold
- if_id_write  out  1  IF/ID write-enable; 0 = hold
- rs_EX, rt_EX, rd_EX  out  5 each  registered register fields
- write_dst_EX  out  5  registered destination (rd if reg_dst, else rt)
- rd1_EX, rd2_EX, imm_EX  out  DW each  registered data
- reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX, alu_src_EX, reg_dst_EX  out  1 each  registered control
- alu_op_EX  out  2  registered ALU op class
- stall_count  out  CW  total stall cycles since reset

Behaviour:

Reset:
- Asynchronous on reset_n=0: every registered output and stall_count clear to 0.
- pc_write=1 and if_id_write=1, because there is no hazard with zeroed state.

Source decode from inst_ID (op=[31:26], rs=[25:21], rt=[20:16]):
- uses_rs for op in {0,4,5,8,10,12,13,35,43}.
- uses_rt for op in {0,4,5}.
- sw (43) rt never stalls; the MEM-stage memory-source forward covers it.
- is_branch = op 4 or 5.
- Register 0 never matches any hazard.

Hazard conditions (combinational; any true -> hazard=1):
- H1 load-use: mem_read_EX=1 and write_dst_EX!=0 and write_dst_EX equals a used source.
- H2 branch on ALU result: is_branch and reg_write_EX=1 and write_dst_EX!=0 and write_dst_EX equals rs or rt.
- H3 branch on load in MEM: is_branch and mem_read_MEM=1 and write_dst_MEM!=0 and write_dst_MEM equals rs or rt.
- Resulting stall length for a branch after an adjacent load: 2 cycles (H1/H2, then H3). Branch after an adjacent ALU op: 1 cycle. Non-branch after a load: 1 cycle.

Hazard outputs:
- pc_write = !hazard.
- if_id_write = !hazard.
- Both are combinational, with no added latency.

Posedge update of ID/EX (1-cycle latency):
- If hazard or ex_flush: load a bubble. All control outputs = 0 and alu_op_EX=0; rs/rt/rd/write_dst_EX = 0; data fields = 0.
- Else: load every ID field. rs/rt/rd come from inst_ID[25:21]/[20:16]/[15:11]; write_dst_EX = reg_dst_ID ? rd : rt.
- hazard and ex_flush together: bubble, and pc_write/if_id_write still follow hazard.
- Reset mid-stall: registers clear immediately. The stall ends because the zeroed EX state cannot match.

stall_count:
- Increments by 1 on each posedge where hazard=1.
- Wraps modulo 2^CW.
- ex_flush alone does not count.

Test Plan:
1. Reset then release: all EX outputs = 0, pc_write=1, if_id_write=1, stall_count=0. Assert reset_n=0 mid-operation -> outputs go to 0 before the next edge.
2. lw $2,0($1) followed by add $3,$2,$4 -> one cycle with pc_write=0 and if_id_write=0. Bubble in EX: reg_write_EX=0, write_dst_EX=0. Then add enters EX with rs_EX=2, write_dst_EX=3. stall_count=1.
3. lw $5 followed by beq $5,$6 -> two consecutive stall cycles (H1, then H3 with write_dst_MEM=5); stall_count=2. addi $5 followed by beq $5,$0 -> exactly one stall.
4. lw $2 followed by sw $2,4($7) -> no stall; sw reaches EX with rt_EX=2 and mem_write_EX=1. lw $0 followed by add $3,$0,$0 -> no stall.
5. ex_flush=1 with a valid add $3,$1,$2 in ID -> EX gets a bubble; pc_write=1; stall_count unchanged. ex_flush together with a load-use hazard -> bubble and pc_write=0.
6. R-type with reg_dst_ID=1, rd=9 -> write_dst_EX=9. I-type with reg_dst_ID=0, rt=4 -> write_dst_EX=4. All data fields (e.g. rd1_ID=0xDEADBEEF) appear on the EX outputs one cycle later.
